fpu_issue_queue: RTL and testbench

//  Buffered issue stage directly upstream of the combinational bfloat16 fpu.

---
 rtl/data_type_pkg.sv | 28 ++
 rtl/fpu.sv | 84 ++++++++
 rtl/fpu_req_fifo.sv | 50 +++++
 rtl/fpu_issue_queue.sv | 100 ++++++++++
 tb/tb_fpu_issue_queue.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_type_pkg.sv
// Shared types for the bfloat16 fpu issue path: request/response records,
// opcode values decoded by fpu, and the output-stage state encoding.
package data_type_pkg;

  localparam int FPU_TAG_W = 4;

  localparam logic [3:0] FPU_OP_ADD = 4'd0;
  localparam logic [3:0] FPU_OP_MUL = 4'd1;

  typedef struct packed {
    logic [3:0]           op;
    logic [15:0]          in1;
    logic [15:0]          in2;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_req_t;

  typedef struct packed {
    logic [15:0]          out;
    logic                 overflow;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_rsp_t;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/fpu.sv
// Combinational bfloat16 add/mul. Results truncate toward zero, subnormals flush
// to zero, and exponent overflow returns signed infinity with overflow_o set.
module fpu
  import data_type_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [15:0] in1_i,
  input  logic [15:0] in2_i,
  output logic [15:0] out_o,
  output logic        overflow_o
);

  // {overflow, bf16} from sign, unbiased-plus-127 exponent and fraction
  function automatic logic [16:0] pack_bf16(input logic s, input logic signed [10:0] e,
                                            input logic [6:0] f);
    if (e >= 11'sd255) return {1'b1, s, 8'hFF, 7'd0};
    if (e <= 11'sd0)   return 17'd0;
    return {1'b0, s, e[7:0], f};
  endfunction

  logic [7:0]  e1, e2, m1, m2;
  logic [15:0] prod;
  logic signed [10:0] mul_e;
  logic [6:0]  mul_f;
  logic [16:0] mul_r;

  assign e1 = in1_i[14:7];
  assign e2 = in2_i[14:7];
  assign m1 = (e1 == 8'd0) ? 8'd0 : {1'b1, in1_i[6:0]};
  assign m2 = (e2 == 8'd0) ? 8'd0 : {1'b1, in2_i[6:0]};

  always_comb begin
    prod  = {8'd0, m1} * {8'd0, m2};
    mul_e = $signed({3'b0, e1}) + $signed({3'b0, e2}) - 11'sd127;
    mul_f = prod[13:7];
    if (prod[15]) begin
      mul_e = mul_e + 11'sd1;
      mul_f = prod[14:8];
    end
    mul_r = (m1 == 8'd0 || m2 == 8'd0) ? 17'd0 : pack_bf16(in1_i[15] ^ in2_i[15], mul_e, mul_f);
  end

  // Adder keeps 24 guard bits below the aligned significands before normalising.
  logic        swap, big_s, sml_s;
  logic [7:0]  big_e, sml_e, big_m, sml_m, diff;
  logic [32:0] big_v, sml_v, sum, norm;
  logic [5:0]  lz;
  logic signed [10:0] add_e;
  logic [16:0] add_r;

  always_comb begin
    swap  = {e2, in2_i[6:0]} > {e1, in1_i[6:0]};
    big_s = swap ? in2_i[15] : in1_i[15];
    sml_s = swap ? in1_i[15] : in2_i[15];
    big_e = swap ? e2 : e1;
    sml_e = swap ? e1 : e2;
    big_m = swap ? m2 : m1;
    sml_m = swap ? m1 : m2;
    diff  = big_e - sml_e;
    big_v = {1'b0, big_m, 24'd0};
    sml_v = (diff > 8'd31) ? 33'd0 : ({1'b0, sml_m, 24'd0} >> diff);
    sum   = (big_s == sml_s) ? big_v + sml_v : big_v - sml_v;
    lz    = 6'd0;
    for (int i = 0; i <= 32; i++) begin
      if (sum[i]) lz = 6'(32 - i);
    end
    norm  = sum << lz;
    add_e = $signed({3'b0, big_e}) + 11'sd1 - $signed({5'b0, lz});
    add_r = (sum == 33'd0) ? 17'd0 : pack_bf16(big_s, add_e, norm[31:25]);
  end

  always_comb begin
    {overflow_o, out_o} = 17'd0;
    case (op_i)
      FPU_OP_ADD: {overflow_o, out_o} = add_r;
      FPU_OP_MUL: {overflow_o, out_o} = mul_r;
      default:    {overflow_o, out_o} = 17'd0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{prod[6:0], norm[32], norm[24:0]};

endmodule

// File: rtl/fpu_req_fifo.sv
// DEPTH-entry circular buffer of fpu requests; the caller guarantees push only
// when not full and pop only when not empty. flush empties it in one edge.
module fpu_req_fifo
  import data_type_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fpu_req_t         wdata,
  input  logic             pop,
  output fpu_req_t         rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fpu_req_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fpu_issue_queue.sv
// Queued issue stage in front of the bfloat16 fpu with a registered result port.
// Define FPU_OVF_CNT_EN to add ovf_cnt_o, a saturating count of overflowed results taken.
module fpu_issue_queue
  import data_type_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = FPU_TAG_W  // must equal FPU_TAG_W, the width carried in fpu_req_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [3:0]                 req_op_i,
  input  logic [15:0]                req_in1_i,
  input  logic [15:0]                req_in2_i,
  input  logic [TAG_W-1:0]           req_tag_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [15:0]                rsp_out_o,
  output logic                       rsp_overflow_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
`ifdef FPU_OVF_CNT_EN
  output logic [15:0]                ovf_cnt_o,
`endif
  output out_state_e                 out_state_o
);

  // Handshakes: a transfer happens at a rising edge where valid && ready; ready never
  // depends on the same port's valid, and a producer holds its payload while stalled.
  fpu_req_t   push_req, head;
  logic       push, pop, fifo_empty, fifo_full;
  logic [15:0] fpu_out;
  logic       fpu_ovf;
  out_state_e state_q;

  assign req_ready_o = !rst_i && !flush_i && !fifo_full;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = !flush_i && !fifo_empty && (state_q == OUT_EMPTY || rsp_ready_i);
  assign push_req    = '{op: req_op_i, in1: req_in1_i, in2: req_in2_i, tag: req_tag_i};

  fpu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .count (count_o),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  fpu u_fpu (
    .op_i       (head.op),
    .in1_i      (head.in1),
    .in2_i      (head.in2),
    .out_o      (fpu_out),
    .overflow_o (fpu_ovf)
  );

  // Result register is only rewritten on a pop, so it holds while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= OUT_EMPTY;
      rsp_out_o      <= '0;
      rsp_overflow_o <= 1'b0;
      rsp_tag_o      <= '0;
    end else if (flush_i) begin
      state_q <= OUT_EMPTY;
    end else begin
      case (state_q)
        OUT_EMPTY: if (pop) state_q <= OUT_FULL;
        OUT_FULL:  if (rsp_ready_i && !pop) state_q <= OUT_EMPTY;
        default:   state_q <= OUT_EMPTY;
      endcase
      if (pop) begin
        rsp_out_o      <= fpu_out;
        rsp_overflow_o <= fpu_ovf;
        rsp_tag_o      <= head.tag;
      end
    end
  end

  assign rsp_valid_o = (state_q == OUT_FULL);
  assign out_state_o = state_q;

`ifdef FPU_OVF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_cnt_o <= '0;
    end else if (rsp_valid_o && rsp_ready_i && rsp_overflow_o && ovf_cnt_o != 16'hFFFF) begin
      ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed and randomized checks of fpu_issue_queue against a real-arithmetic
// bfloat16 model; build with FPU_OVF_CNT_EN to also cover ovf_cnt_o.
module tb_fpu_issue_queue;
  import data_type_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int W     = 16 + 1 + TAG_W;
  localparam int N_RAND = 10000;

  logic              clk, rst, flush, req_valid, req_ready, rsp_valid, rsp_ready, rsp_ovf;
  logic [3:0]        req_op;
  logic [15:0]       req_in1, req_in2, rsp_out;
  logic [TAG_W-1:0]  req_tag, rsp_tag;
  logic [$clog2(DEPTH+1)-1:0] count;
  out_state_e        out_state;
`ifdef FPU_OVF_CNT_EN
  logic [15:0]       ovf_cnt;
  int                ovf_exp;
`endif

  int tests, fails, n_acc;
  logic [W-1:0] exp_q[$];

  fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_in1_i      (req_in1),
    .req_in2_i      (req_in2),
    .req_tag_i      (req_tag),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_out_o      (rsp_out),
    .rsp_overflow_o (rsp_ovf),
    .rsp_tag_o      (rsp_tag),
    .count_o        (count),
`ifdef FPU_OVF_CNT_EN
    .ovf_cnt_o      (ovf_cnt),
`endif
    .out_state_o    (out_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded its time budget (tests=%0d failed=%0d)", tests, fails);
    $fatal(1);
  end

  // bfloat16 reference model in plain real arithmetic
  function automatic real bf2r(input logic [15:0] v);
    real m;
    int  e;
    if (v[14:7] == 8'd0) return 0.0;
    m = 1.0 + real'(int'(v[6:0])) / 128.0;
    e = int'(v[14:7]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[15] ? -m : m;
  endfunction

  function automatic logic [16:0] r2bf(input real r);
    real        a;
    int         e;
    logic       s;
    logic [6:0] f;
    if (r == 0.0) return 17'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e + 127 >= 255) return {1'b1, s, 8'hFF, 7'd0};
    if (e + 127 <= 0)   return 17'd0;
    f = 7'($rtoi((a - 1.0) * 128.0));
    return {1'b0, s, 8'(e + 127), f};
  endfunction

  function automatic logic [15:0] int2bf(input int n);
    logic [16:0] r;
    r = r2bf(real'(n));
    return r[15:0];
  endfunction

  function automatic logic [16:0] ref_fpu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    if (op == FPU_OP_ADD) return r2bf(bf2r(a) + bf2r(b));
    if (op == FPU_OP_MUL) return r2bf(bf2r(a) * bf2r(b));
    return 17'd0;
  endfunction

  // checker
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // one clock: record handshakes at the falling edge, return just after the next rising edge
  task automatic tick();
    logic [16:0]  r;
    logic [W-1:0] e_rec;
    @(negedge clk);
    if (req_valid && req_ready) begin
      r = ref_fpu(req_op, req_in1, req_in2);
      exp_q.push_back({r[15:0], r[16], req_tag});
      n_acc++;
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_extra", 32'(rsp_valid), 32'd0);
      end else begin
        e_rec = exp_q.pop_front();
        check("rsp_data", 32'({rsp_out, rsp_ovf, rsp_tag}), 32'(e_rec));
`ifdef FPU_OVF_CNT_EN
        if (e_rec[TAG_W] && ovf_exp < 65535) ovf_exp++;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [TAG_W-1:0] t);
    req_valid = v;
    req_op    = op;
    req_in1   = a;
    req_in2   = b;
    req_tag   = t;
  endtask

  task automatic wait_rsp(input int max_cycles, input string name);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_rsp_out"},   32'(rsp_out),   32'd0);
    check({name, "_rsp_ovf"},   32'(rsp_ovf),   32'd0);
    check({name, "_rsp_tag"},   32'(rsp_tag),   32'd0);
    check({name, "_count"},     32'(count),     32'd0);
    check({name, "_state"},     32'(out_state), 32'(OUT_EMPTY));
`ifdef FPU_OVF_CNT_EN
    check({name, "_ovf_cnt"},   32'(ovf_cnt),   32'd0);
`endif
  endtask

  initial begin
    int k, n0, guard, kind;
    logic [16:0] r;
    tests = 0; fails = 0; n_acc = 0;
    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    set_req(1'b0, FPU_OP_ADD, 16'd0, 16'd0, '0);
`ifdef FPU_OVF_CNT_EN
    ovf_exp = 0;
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single ADD, two-cycle latency
    rsp_ready = 1'b1;
    set_req(1'b1, FPU_OP_ADD, 16'h3F80, 16'h3F80, 4'd3);
    check("t1_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("t1_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_result", 32'({rsp_out, rsp_ovf, rsp_tag}), 32'({16'h4000, 1'b0, 4'd3}));
    tick();
    check("t1_drained", 32'(rsp_valid), 32'd0);

    // 2: burst of DEPTH+2 MULs against a stalled consumer
    rsp_ready = 1'b0;
    n0 = n_acc;
    k = 0;
    for (int c = 0; c < DEPTH + 6; c++) begin
      set_req(1'b1, FPU_OP_MUL, int2bf(k + 2), int2bf(3), TAG_W'(k));
      tick();
      if (n_acc - n0 > k) k++;
    end
    check("t2_accepts", 32'(n_acc - n0), 32'(DEPTH + 1));
    check("t2_ready_low", 32'(req_ready), 32'd0);
    check("t2_count", 32'(count), 32'(DEPTH));
    for (int c = 0; c < 3; c++) begin
      check("t2_hold", 32'({rsp_valid, rsp_out, rsp_ovf, rsp_tag}), 32'({1'b1, exp_q[0]}));
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) begin
      check("t2_stream_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    check("t2_stream_end", 32'(rsp_valid), 32'd0);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: overflowing multiply; counter moves on the handshake edge only
    rsp_ready = 1'b0;
    set_req(1'b1, FPU_OP_MUL, 16'h7F00, 16'h7F00, 4'd9);
    tick();
    req_valid = 1'b0;
    wait_rsp(5, "t3_valid");
    check("t3_result", 32'({rsp_out, rsp_ovf, rsp_tag}), 32'({16'h7F80, 1'b1, 4'd9}));
`ifdef FPU_OVF_CNT_EN
    tick();
    check("t3_cnt_before", 32'(ovf_cnt), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("t3_cnt_after", 32'(ovf_cnt), 32'(ovf_exp));
`else
    rsp_ready = 1'b1;
    tick();
`endif
    check("t3_drained", 32'(rsp_valid), 32'd0);

    // 4: flush with a full queue and a held result
    rsp_ready = 1'b0;
    k = 0;
    set_req(1'b1, FPU_OP_ADD, int2bf(5), int2bf(7), 4'd1);
    while (req_ready && k < DEPTH + 4) begin
      tick();
      k++;
    end
    check("t4_full_count", 32'(count), 32'(DEPTH));
    check("t4_full_valid", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    check("t4_flush_ready", 32'(req_ready), 32'd0);
    tick();
    exp_q.delete();
    check("t4_valid_dropped", 32'(rsp_valid), 32'd0);
    check("t4_count_zero", 32'(count), 32'd0);
    check("t4_flush_blocks", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("t4_no_accept", 32'(count), 32'd0);
    tick();
    tick();
    check("t4_quiet", 32'(rsp_valid), 32'd0);

    // 5: asynchronous reset in the middle of a burst
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(1'b1, FPU_OP_MUL, int2bf(c + 5), int2bf(11), TAG_W'(c + 4));
      tick();
    end
    req_valid = 1'b0;
    check("t5_busy", 32'(rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("t5_async");
    exp_q.delete();
`ifdef FPU_OVF_CNT_EN
    ovf_exp = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    set_req(1'b1, FPU_OP_ADD, 16'h4000, 16'h3F80, 4'hA);
    tick();
    req_valid = 1'b0;
    wait_rsp(5, "t5_valid");
    check("t5_result", 32'({rsp_out, rsp_ovf, rsp_tag}), 32'({16'h4040, 1'b0, 4'hA}));
    tick();

    // 6: randomized valid/ready traffic against the model
    n0 = n_acc;
    guard = 0;
    req_valid = 1'b0;
    while (n_acc - n0 < N_RAND && guard < 60000) begin
      if (!req_valid && $urandom_range(3) != 0) begin
        kind = int'($urandom_range(3));
        case (kind)
          0: set_req(1'b1, FPU_OP_ADD, int2bf(int'($urandom_range(200)) - 100),
                     int2bf(int'($urandom_range(200)) - 100), TAG_W'($urandom));
          1: set_req(1'b1, FPU_OP_MUL, int2bf(int'($urandom_range(30)) - 15),
                     int2bf(int'($urandom_range(30)) - 15), TAG_W'($urandom));
          2: set_req(1'b1, FPU_OP_MUL, {1'($urandom), 8'($urandom_range(254, 150)), 7'd0},
                     {1'($urandom), 8'($urandom_range(254, 150)), 7'd0}, TAG_W'($urandom));
          default: set_req(1'b1, FPU_OP_ADD, {1'b0, 8'($urandom_range(254, 240)), 7'($urandom)},
                           {1'b0, 8'($urandom_range(254, 240)), 7'($urandom)}, TAG_W'($urandom));
        endcase
      end
      rsp_ready = ($urandom_range(3) != 0);
      k = n_acc;
      tick();
      if (n_acc != k) req_valid = 1'b0;
      guard++;
    end
    check("t6_accepted", 32'(n_acc - n0), 32'(N_RAND));
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t6_idle_valid", 32'(rsp_valid), 32'd0);
    check("t6_idle_count", 32'(count), 32'd0);
`ifdef FPU_OVF_CNT_EN
    check("t6_ovf_cnt", 32'(ovf_cnt), 32'(ovf_exp));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
